// File: rtl/cla_arb_pkg.sv
// Shared types and width helpers for the shared-CLA arbiter.
// Holds the FSM state enum and width derivation functions.
package cla_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADD_W  = 2 * DEF_DATA_W;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int add_w(input int dw);
    return 2 * dw;
  endfunction

endpackage

// File: rtl/cla_adder_share_arbiter_if.sv
// Requester/response bundle for the shared-CLA arbiter.
// master: requester side; slave: arbiter side.
interface cla_adder_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADD_W   = 16,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*ADD_W-1:0] req_a;
  logic [NUM_REQ*ADD_W-1:0] req_b;
  logic [NUM_REQ-1:0]       req_cin;
  logic [NUM_REQ-1:0]       req_last;
  logic                     rsp_valid;
  logic [ID_W-1:0]          rsp_id;
  logic [ADD_W-1:0]         rsp_sum;
  logic                     rsp_cout;
  logic                     rsp_last;
  logic                     busy;

  modport master (
    output req_valid, req_a, req_b,
    output req_cin, req_last,
    input  req_ready, rsp_valid, rsp_id,
    input  rsp_sum, rsp_cout, rsp_last, busy
  );

  modport slave (
    input  req_valid, req_a, req_b,
    input  req_cin, req_last,
    output req_ready, rsp_valid, rsp_id,
    output rsp_sum, rsp_cout, rsp_last, busy
  );
endinterface

// File: rtl/carry_lookaheadadder_16bit.sv
// 16-bit two-level carry-lookahead adder (4x4-bit groups).
// Ports: a_i, b_i, cin_i -> sum_o, cout_o.
module carry_lookaheadadder_16bit (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o,
  output logic        cout_o
);
  logic [15:0] g, p, c;
  logic [3:0]  bg, bp;
  logic [4:0]  bc;
  logic        ci;

  always_comb begin
    g  = a_i & b_i;
    p  = a_i ^ b_i;
    bg = '0;
    bp = '0;
    c  = '0;
    ci = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bp[k] = &p[4*k +: 4];
      bg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2]
               & p[4*k+1] & g[4*k]);
    end
    // second level: group carries straight from cin
    bc[0] = cin_i;
    bc[1] = bg[0] | (bp[0] & cin_i);
    bc[2] = bg[1] | (bp[1] & bg[0])
          | (bp[1] & bp[0] & cin_i);
    bc[3] = bg[2] | (bp[2] & bg[1])
          | (bp[2] & bp[1] & bg[0])
          | (bp[2] & bp[1] & bp[0] & cin_i);
    bc[4] = bg[3] | (bp[3] & bg[2])
          | (bp[3] & bp[2] & bg[1])
          | (bp[3] & bp[2] & bp[1] & bg[0])
          | (&bp & cin_i);
    for (int k = 0; k < 4; k++) begin
      ci       = bc[k];
      c[4*k]   = ci;
      c[4*k+1] = g[4*k] | (p[4*k] & ci);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & ci);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & ci);
    end
  end

  assign sum_o  = p ^ c;
  assign cout_o = bc[4];
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker starting at ptr_i.
// Ports: req_i, ptr_i -> gnt_o (one-hot), idx_o, any_o.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);
  int j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr_i) + k) % NUM_REQ;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        idx_o    = ID_W'(j);
        gnt_o[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cla_adder_share_arbiter.sv
// Round-robin share of one 16-bit CLA; bursts lock grant and chain carry.
// Ports: clk, rst (sync, active-high), bus (slave modport of the bundle).
module cla_adder_share_arbiter
  import cla_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_W,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = id_w(NUM_REQ)
) (
  input  logic clk,
  input  logic rst,
  cla_adder_share_arbiter_if.slave bus
);
  localparam int ADD_W = add_w(DATA_WIDTH);
  localparam logic [0:0] S_IDLE = 1'(IDLE);
  localparam logic [0:0] S_LOCK = 1'(LOCK);

  logic [0:0]         state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic               carry_q;
  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [ADD_W-1:0]   rsp_sum_q;
  logic               rsp_cout_q;
  logic               rsp_last_q;
  logic               busy_q;

  logic [NUM_REQ-1:0] gnt_oh, ready;
  logic [ID_W-1:0]    gnt_idx, sel, ptr_nx;
  logic               gnt_any, accept, last;
  logic [ADD_W-1:0]   add_a, add_b, add_s;
  logic               add_ci, add_co;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req_i (bus.req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt_oh),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  carry_lookaheadadder_16bit u_add (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (add_ci),
    .sum_o  (add_s),
    .cout_o (add_co)
  );

  always_comb begin
    sel    = (state_q == S_LOCK) ? owner_q : gnt_idx;
    ready  = '0;
    accept = 1'b0;
    if (!rst) begin
      if (state_q == S_LOCK) begin
        ready[owner_q] = bus.req_valid[owner_q];
        accept         = bus.req_valid[owner_q];
      end else begin
        ready  = gnt_oh;
        accept = gnt_any;
      end
    end
    add_a  = bus.req_a[int'(sel)*ADD_W +: ADD_W];
    add_b  = bus.req_b[int'(sel)*ADD_W +: ADD_W];
    // later beats of a burst continue from the held carry
    add_ci = (state_q == S_LOCK) ? carry_q
                                 : bus.req_cin[sel];
    last   = bus.req_last[sel];
    ptr_nx = (sel == ID_W'(NUM_REQ - 1)) ? '0
                                         : sel + 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      unique case (1'b1)
        (state_q == S_IDLE) && !last: begin
          state_d = S_LOCK;
          owner_d = sel;
        end
        (state_q == S_IDLE) && last: begin
          rr_ptr_d = ptr_nx;
        end
        (state_q == S_LOCK) && last: begin
          state_d  = S_IDLE;
          rr_ptr_d = ptr_nx;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      carry_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      rsp_valid_q <= accept;
      busy_q      <= (state_d == S_LOCK);
      if (accept) begin
        carry_q    <= add_co;
        rsp_id_q   <= sel;
        rsp_sum_q  <= add_s;
        rsp_cout_q <= add_co;
        rsp_last_q <= last;
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_cla_adder_share_arbiter.sv
// Directed bench for cla_adder_share_arbiter.
// Checks handshake, round-robin, bursts, stall and reset.
module tb_cla_adder_share_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  cla_adder_share_arbiter_if #(
    .NUM_REQ (4),
    .ADD_W   (16),
    .ID_W    (2)
  ) bus ();

  cla_adder_share_arbiter #(
    .DATA_WIDTH (8),
    .NUM_REQ    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {valid, id, sum, cout, last}
  logic [20:0] rsp;
  assign rsp = {bus.rsp_valid, bus.rsp_id, bus.rsp_sum,
                bus.rsp_cout, bus.rsp_last};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] a,
                         input logic [15:0] b, input logic ci,
                         input logic lst);
    bus.req_a[i*16 +: 16] = a;
    bus.req_b[i*16 +: 16] = b;
    bus.req_cin[i]        = ci;
    bus.req_last[i]       = lst;
  endtask

  task automatic test_reset();
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_req(i, 16'h1111, 16'h2222, 1'b1, 1'b1);
    step();
    step();
    n_chk++;
    if (bus.req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 0000", bus.req_ready);
    end
    n_chk++;
    if (rsp !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_rsp: got %h want 0", rsp);
    end
    n_chk++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    bus.req_valid = 4'b0000;
    rst = 1'b0;
  endtask

  task automatic test_single();
    set_req(0, 16'h1234, 16'h0001, 1'b0, 1'b1);
    bus.req_valid = 4'b0001;
    #1;
    n_chk++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_ready: got %b want 0001", bus.req_ready);
    end
    step();
    bus.req_valid = 4'b0000;
    n_chk++;
    if (rsp !== {1'b1, 2'd0, 16'h1235, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL single_rsp: got %h want %h", rsp,
               {1'b1, 2'd0, 16'h1235, 1'b0, 1'b1});
    end
    step();
    n_chk++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: rsp_valid got %b want 0", bus.rsp_valid);
    end
  endtask

  task automatic test_carry_wrap();
    set_req(3, 16'hFFFF, 16'h0000, 1'b1, 1'b1);
    bus.req_valid = 4'b1000;
    #1;
    n_chk++;
    if (bus.req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL wrap_ready: got %b want 1000", bus.req_ready);
    end
    step();
    bus.req_valid = 4'b0000;
    n_chk++;
    if (rsp !== {1'b1, 2'd3, 16'h0000, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL wrap_rsp: got %h want %h", rsp,
               {1'b1, 2'd3, 16'h0000, 1'b1, 1'b1});
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  e;
    logic [15:0] s;
    for (int i = 0; i < 4; i++)
      set_req(i, 16'(i * 256), 16'(i), 1'b0, 1'b1);
    bus.req_valid = 4'b1111;
    #1;
    for (int c = 0; c < 8; c++) begin
      e = 2'(c % 4);
      s = 16'((c % 4) * 257);
      n_chk++;
      if (bus.req_ready !== 4'(1 << e)) begin
        n_fail++;
        $display("FAIL rr_ready[%0d]: got %b want %b", c,
                 bus.req_ready, 4'(1 << e));
      end
      step();
      n_chk++;
      if (rsp !== {1'b1, e, s, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL rr_rsp[%0d]: got %h want %h", c, rsp,
                 {1'b1, e, s, 1'b0, 1'b1});
      end
    end
    bus.req_valid = 4'b0000;
    step();
  endtask

  task automatic test_burst32();
    set_req(1, 16'h0010, 16'h0020, 1'b0, 1'b1);
    bus.req_valid = 4'b0010;
    step();
    n_chk++;
    if (rsp !== {1'b1, 2'd1, 16'h0030, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL b32_pre: got %h want %h", rsp,
               {1'b1, 2'd1, 16'h0030, 1'b0, 1'b1});
    end
    set_req(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    bus.req_valid = 4'b0110;
    #1;
    n_chk++;
    if (bus.req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL b32_beat0_ready: got %b want 0100", bus.req_ready);
    end
    step();
    n_chk++;
    if (rsp !== {1'b1, 2'd2, 16'h0000, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL b32_beat0: got %h want %h", rsp,
               {1'b1, 2'd2, 16'h0000, 1'b1, 1'b0});
    end
    n_chk++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b32_busy: got %b want 1", bus.busy);
    end
    set_req(2, 16'h0000, 16'h0000, 1'b0, 1'b1);
    #1;
    n_chk++;
    if (bus.req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL b32_beat1_ready: got %b want 0100", bus.req_ready);
    end
    step();
    bus.req_valid = 4'b0010;
    n_chk++;
    if (rsp !== {1'b1, 2'd2, 16'h0001, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL b32_beat1: got %h want %h", rsp,
               {1'b1, 2'd2, 16'h0001, 1'b0, 1'b1});
    end
    n_chk++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b32_unbusy: got %b want 0", bus.busy);
    end
    n_chk++;
    if (bus.req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL b32_next_ready: got %b want 0010", bus.req_ready);
    end
    step();
    bus.req_valid = 4'b0000;
    n_chk++;
    if (rsp !== {1'b1, 2'd1, 16'h0030, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL b32_next: got %h want %h", rsp,
               {1'b1, 2'd1, 16'h0030, 1'b0, 1'b1});
    end
  endtask

  task automatic test_lock_stall();
    set_req(0, 16'h8000, 16'h8000, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++)
      set_req(i, 16'h0100, 16'h0001, 1'b0, 1'b1);
    bus.req_valid = 4'b0001;
    step();
    bus.req_valid = 4'b1110;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_chk++;
      if (bus.req_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL stall_ready[%0d]: got %b want 0000", c,
                 bus.req_ready);
      end
      step();
      n_chk++;
      if (rsp !== {1'b0, 2'd0, 16'h0000, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_rsp[%0d]: got %h want %h", c, rsp,
                 {1'b0, 2'd0, 16'h0000, 1'b1, 1'b0});
      end
    end
    set_req(0, 16'h0001, 16'h0002, 1'b0, 1'b1);
    bus.req_valid = 4'b1111;
    #1;
    n_chk++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL stall_resume_ready: got %b want 0001", bus.req_ready);
    end
    step();
    bus.req_valid = 4'b1110;
    n_chk++;
    if (rsp !== {1'b1, 2'd0, 16'h0004, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL stall_resume: got %h want %h", rsp,
               {1'b1, 2'd0, 16'h0004, 1'b0, 1'b1});
    end
    n_chk++;
    if (bus.req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL stall_next_ready: got %b want 0010", bus.req_ready);
    end
    step();
    bus.req_valid = 4'b0000;
    n_chk++;
    if (rsp !== {1'b1, 2'd1, 16'h0101, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL stall_next: got %h want %h", rsp,
               {1'b1, 2'd1, 16'h0101, 1'b0, 1'b1});
    end
  endtask

  task automatic test_reset_mid_burst();
    set_req(2, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    bus.req_valid = 4'b0100;
    step();
    n_chk++;
    if ({bus.busy, rsp} !== {1'b1, 1'b1, 2'd2, 16'hFFFF, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL rmb_beat0: got %h want %h", {bus.busy, rsp},
               {1'b1, 1'b1, 2'd2, 16'hFFFF, 1'b1, 1'b0});
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (bus.req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL rmb_ready: got %b want 0000", bus.req_ready);
    end
    step();
    rst = 1'b0;
    n_chk++;
    if ({bus.busy, rsp} !== 22'd0) begin
      n_fail++;
      $display("FAIL rmb_clear: got %h want 0", {bus.busy, rsp});
    end
    set_req(1, 16'h0010, 16'h0020, 1'b0, 1'b1);
    set_req(2, 16'h0001, 16'h0001, 1'b0, 1'b1);
    bus.req_valid = 4'b0110;
    #1;
    n_chk++;
    if (bus.req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL rmb_ptr: got %b want 0010", bus.req_ready);
    end
    step();
    n_chk++;
    if (rsp !== {1'b1, 2'd1, 16'h0030, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL rmb_req1: got %h want %h", rsp,
               {1'b1, 2'd1, 16'h0030, 1'b0, 1'b1});
    end
    n_chk++;
    if (bus.req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL rmb_restart_ready: got %b want 0100", bus.req_ready);
    end
    step();
    bus.req_valid = 4'b0000;
    n_chk++;
    if ({bus.busy, rsp} !== {1'b0, 1'b1, 2'd2, 16'h0002, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL rmb_restart: got %h want %h", {bus.busy, rsp},
               {1'b0, 1'b1, 2'd2, 16'h0002, 1'b0, 1'b1});
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.req_last  = '0;
    test_reset();
    test_single();
    test_carry_wrap();
    test_round_robin();
    test_burst32();
    test_lock_stall();
    test_reset_mid_burst();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cla_adder_share_arbiter.md
Name: cla_adder_share_arbiter

Overview:
Shares one carry_lookaheadadder_16bit instance among NUM_REQ requesters in the matrix-multiplier datapath (e.g. partial-product accumulators). Arbitration is round-robin with a valid/ready handshake per requester. Multi-beat bursts lock the grant and chain the carry between beats, so wider additions (32/48/64-bit) run on the shared 16-bit adder. Results are registered and broadcast with a requester ID.

Parameters:
DATA_WIDTH, 8, half adder width; adder/operand width ADD_W = 2*DATA_WIDTH
NUM_REQ, 4, number of requesters (2..8)
ID_W, $clog2(NUM_REQ), width of requester index

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
req_valid  in  NUM_REQ  per-requester beat valid
req_ready  out  NUM_REQ  per-requester beat accepted (one-hot or zero)
req_a  in  NUM_REQ*ADD_W  operand A per requester, requester i at [i*ADD_W +: ADD_W]
req_b  in  NUM_REQ*ADD_W  operand B per requester, same packing
req_cin  in  NUM_REQ  carry-in, used on first beat of a burst only
req_last  in  NUM_REQ  beat is final beat of burst (1 = single-beat op)
rsp_valid  out  1  registered result valid
rsp_id  out  ID_W  requester index of result
rsp_sum  out  ADD_W  sum of accepted beat
rsp_cout  out  1  carry-out of accepted beat
rsp_last  out  1  copy of req_last of accepted beat
busy  out  1  high while in LOCK

Behaviour:
- Clock/reset: one clock clk; reset rst is synchronous, active-high.
- Reset values: state IDLE, rr_ptr 0, owner 0, carry_reg 0, rsp_valid 0, rsp_id 0, rsp_sum 0, rsp_cout 0, rsp_last 0, busy 0. req_ready is 0 while rst is high.
- FSM states: IDLE and LOCK.
- IDLE arbitration:
  - grant = first i with req_valid[i], searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - req_ready[grant] = 1 combinationally in the same cycle. No valid requester means no ready.
  - Adder inputs: req_a[grant], req_b[grant], cin = req_cin[grant].
- LOCK arbitration:
  - Only owner is eligible: req_ready[owner] = req_valid[owner]. All other readies are 0.
  - Adder cin = carry_reg. req_cin is ignored.
  - If the owner deasserts valid, the block stalls indefinitely: no timeout, carry_reg held, other requesters starved.
- A beat is accepted when valid && ready. On acceptance, the next edge loads:
  - rsp_valid = 1, rsp_id = grant, rsp_sum, rsp_cout = adder cout, rsp_last = req_last[grant]
  - carry_reg = adder cout
- A cycle with no acceptance loads rsp_valid = 0. The other rsp fields hold.
- Latency is 1 cycle from acceptance to rsp_valid. Throughput is one beat per cycle. rsp has no backpressure; consumers must sink every result.
- Transitions:
  - IDLE, accept with req_last = 0: go to LOCK, owner = grant.
  - IDLE, accept with req_last = 1: stay in IDLE, rr_ptr = grant+1 mod NUM_REQ.
  - LOCK, accept with req_last = 1: go to IDLE, rr_ptr = owner+1 mod NUM_REQ.
  - LOCK, accept with req_last = 0: stay in LOCK.
- A new burst may be granted in the cycle after the previous burst's last beat, with no bubble.
- Arithmetic: {rsp_cout, rsp_sum} = a + b + cin, modulo 2^(ADD_W+1). There is no overflow flag; signed interpretation is the consumer's concern.
- Reset mid-burst: the burst is abandoned, state returns to IDLE, and the result register clears. The requester must restart the burst from its first beat.
- busy = (state == LOCK), registered.

Decomposition:
- Package cla_arb_pkg:
  - state enum {IDLE, LOCK}
  - function clog2-based ID width helper
  - localparam ADD_W derivation
- Sub-module rr_arbiter (NUM_REQ): combinational round-robin picker. Inputs are the request vector and rr_ptr; outputs are a one-hot grant, grant index and any-grant.
- The FSM, carry_reg, result register and carry_lookaheadadder_16bit instance live in the top.

Test Plan:
1. Single beat: req0 a=0x1234 b=0x0001 cin=0 last=1 → req_ready[0]=1 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_sum=0x1235, rsp_cout=0, rsp_last=1.
2. Carry-in and wrap: req3 a=0xFFFF b=0x0000 cin=1 → rsp_sum=0x0000, rsp_cout=1.
3. Round-robin fairness: all four requesters valid with single beats for 8 cycles → grants 0,1,2,3,0,1,2,3; rsp_id follows one cycle later.
4. 32-bit burst:
   - Stimulus: req2 beat0 a=0xFFFF b=0x0001 cin=0 last=0; beat1 a=0x0000 b=0x0000 last=1. req1 is valid throughout.
   - Response: results (0x0000, cout 1) then (0x0001, cout 0); busy=1 between the beats; req_ready[1]=0 until after beat1; req1 granted the following cycle.
5. Lock stall: in LOCK the owner drops valid for 3 cycles while the others are valid → no readies asserted, rsp_valid=0, carry_reg preserved; the resumed beat uses the held carry.
6. Reset mid-burst: rst for 1 cycle after beat0 → state IDLE, busy=0, rsp_valid=0, rr_ptr=0; the next beat from the former owner uses req_cin, not the stale carry.
